// File: rtl/reg_dump_if.sv
// Bundle of the dump-control, register-read and consumer-handshake signals of reg_dump.
// The slave modport is the dump engine; the master modport is whatever drives it.
interface reg_dump_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] regdata;
    logic              ready;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] daddr;
    logic              valid;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, first_addr, last_addr, regdata, ready,
        input  rdaddress, dout, daddr, valid, busy, done
    );

    modport slave (
        input  start, abort, first_addr, last_addr, regdata, ready,
        output rdaddress, dout, daddr, valid, busy, done
    );
endinterface

// File: rtl/reg_dump.sv
// Walks a wrapping register range through one read port and streams each word out over valid/ready.
// Every output is a register; o_state exposes the FSM state for debug.
module reg_dump #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    reg_dump_if.slave   bus,
    output logic [1:0]  o_state
);
    // Handshake: a word transfers on a rising edge where valid && ready; dout/daddr/valid
    // hold while ready is low, and abort cancels the word even if ready is high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_rdaddress;
    logic [DATA_W-1:0] r_dout;
    logic [ADDR_W-1:0] r_daddr;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_last;
    logic [ADDR_W-1:0] w_rdaddress;
    logic [DATA_W-1:0] w_dout;
    logic [ADDR_W-1:0] w_daddr;
    logic              w_valid;
    logic              w_busy;
    logic              w_done;

    logic              w_launch;
    logic              w_last_word;

    assign w_launch    = bus.start && !bus.abort;
    assign w_last_word = (r_daddr == r_last);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                w_next_state = bus.abort ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (bus.ready) begin
                    w_next_state = w_last_word ? S_IDLE : S_ADDR;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; anything not assigned below holds.
    always_comb begin
        w_last      = r_last;
        w_rdaddress = r_rdaddress;
        w_dout      = r_dout;
        w_daddr     = r_daddr;
        w_valid     = r_valid;
        w_busy      = r_busy;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_last      = bus.last_addr;
                    w_rdaddress = bus.first_addr;
                    w_busy      = 1'b1;
                end
            end
            S_ADDR: begin
                if (bus.abort) begin
                    w_valid = 1'b0;
                    w_busy  = 1'b0;
                end else begin
                    w_dout  = bus.regdata;
                    w_daddr = r_rdaddress;
                    w_valid = 1'b1;
                end
            end
            S_SEND: begin
                if (bus.abort) begin
                    w_valid = 1'b0;
                    w_busy  = 1'b0;
                end else if (bus.ready) begin
                    w_valid = 1'b0;
                    if (w_last_word) begin
                        w_busy = 1'b0;
                        w_done = 1'b1;
                    end else begin
                        // Natural width overflow gives the wrap from the top register to 0.
                        w_rdaddress = r_rdaddress + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last      <= '0;
            r_rdaddress <= '0;
            r_dout      <= '0;
            r_daddr     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_last      <= w_last;
            r_rdaddress <= w_rdaddress;
            r_dout      <= w_dout;
            r_daddr     <= w_daddr;
            r_valid     <= w_valid;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign bus.rdaddress = r_rdaddress;
    assign bus.dout      = r_dout;
    assign bus.daddr     = r_daddr;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign o_state       = r_state;
endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a behavioural 8x8 register file with a 2-unit read delay
// feeds the DUT; each task drives one scenario and checks against hand-computed values.
module tb_reg_dump;
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    logic [7:0] regs [8];

    int n_checks;
    int n_errors;

    logic [2:0] got_addr [$];
    logic [7:0] got_data [$];
    logic [2:0] e0_rdaddr;
    logic       e0_busy;
    logic       e1_valid;
    logic [7:0] e1_dout;
    bit         stall_moved;

    reg_dump_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    reg_dump #(.DATA_W(8), .ADDR_W(3)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    assign #2 bus.regdata = regs[bus.rdaddress];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs(input logic [7:0] base);
        for (int i = 0; i < 8; i++) regs[i] = base + 8'(i);
    endtask

    // Runs one dump with optional stall/start-pulse, logging each handshake and the DONE edge.
    task automatic run_dump(input logic [2:0] f, input logic [2:0] l, input int stall_word,
                            input int stall_cycles, input bit pulse_start, output int done_edge);
        int edge_n;
        int stalled;
        logic [2:0] hold_a;
        logic [7:0] hold_d;
        got_addr.delete();
        got_data.delete();
        stall_moved = 1'b0;
        done_edge = -1;
        stalled = 0;
        hold_a = '0;
        hold_d = '0;
        bus.first_addr = f;
        bus.last_addr  = l;
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.start = 1'b0;
        e0_rdaddr = bus.rdaddress;
        e0_busy   = bus.busy;
        edge_n = 0;
        while (edge_n < 80) begin
            if (pulse_start && edge_n == 2) begin
                bus.start = 1'b1;
                bus.first_addr = 3'd7;
                bus.last_addr  = 3'd7;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.valid && got_addr.size() == stall_word && stalled < stall_cycles) begin
                if (stalled == 0) begin
                    hold_a = bus.daddr;
                    hold_d = bus.dout;
                end else if (bus.daddr !== hold_a || bus.dout !== hold_d) begin
                    stall_moved = 1'b1;
                end
                bus.ready = 1'b0;
                stalled++;
            end else begin
                if (stalled > 0 && bus.valid && got_addr.size() == stall_word &&
                    (bus.daddr !== hold_a || bus.dout !== hold_d)) stall_moved = 1'b1;
                bus.ready = 1'b1;
            end
            if (bus.valid && bus.ready) begin
                got_addr.push_back(bus.daddr);
                got_data.push_back(bus.dout);
            end
            tick();
            edge_n++;
            if (edge_n == 1) begin
                e1_valid = bus.valid;
                e1_dout  = bus.dout;
            end
            if (bus.done === 1'b1) begin
                done_edge = edge_n;
                break;
            end
        end
        bus.start = 1'b0;
        bus.ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.rdaddress !== 3'd0) begin n_errors++; $display("FAIL reset_rdaddress got %0h exp 0", bus.rdaddress); end
        n_checks++; if (bus.dout !== 8'd0) begin n_errors++; $display("FAIL reset_dout got %0h exp 0", bus.dout); end
        n_checks++; if (bus.daddr !== 3'd0) begin n_errors++; $display("FAIL reset_daddr got %0h exp 0", bus.daddr); end
        n_checks++; if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got %b exp 000", {bus.valid, bus.busy, bus.done}); end
        n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        bus.start = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_release_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_full_dump();
        int de;
        run_dump(3'd0, 3'd7, -1, 0, 1'b0, de);
        n_checks++; if (e0_rdaddr !== 3'd0 || e0_busy !== 1'b1) begin n_errors++; $display("FAIL full_edge0 got rdaddr=%0d busy=%b exp rdaddr=0 busy=1", e0_rdaddr, e0_busy); end
        n_checks++; if (e1_valid !== 1'b1 || e1_dout !== 8'h10) begin n_errors++; $display("FAIL full_edge1 got valid=%b dout=%0h exp valid=1 dout=10", e1_valid, e1_dout); end
        n_checks++; if (de !== 16) begin n_errors++; $display("FAIL full_done_edge got %0d exp 16", de); end
        n_checks++; if (got_addr.size() !== 8) begin n_errors++; $display("FAIL full_count got %0d exp 8", got_addr.size()); end
        for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
            n_checks++; if (got_addr[i] !== 3'(i) || got_data[i] !== 8'h10 + 8'(i)) begin n_errors++; $display("FAIL full_word%0d got %0d/%0h exp %0d/%0h", i, got_addr[i], got_data[i], i, 8'h10 + 8'(i)); end
        end
        n_checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin n_errors++; $display("FAIL full_idle_at_done got busy=%b valid=%b exp 0 0", bus.busy, bus.valid); end
        tick();
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL full_done_pulse got %b exp 0", bus.done); end
    endtask

    task automatic test_wrap();
        int de;
        logic [2:0] exp_a [4];
        exp_a = '{3'd6, 3'd7, 3'd0, 3'd1};
        load_regs(8'hA0);
        run_dump(3'd6, 3'd1, -1, 0, 1'b0, de);
        n_checks++; if (de !== 8 || got_addr.size() !== 4) begin n_errors++; $display("FAIL wrap_len got done=%0d words=%0d exp 8 4", de, got_addr.size()); end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            n_checks++; if (got_addr[i] !== exp_a[i] || got_data[i] !== 8'hA0 + 8'(exp_a[i])) begin n_errors++; $display("FAIL wrap_word%0d got %0d/%0h exp %0d/%0h", i, got_addr[i], got_data[i], exp_a[i], 8'hA0 + 8'(exp_a[i])); end
        end
        load_regs(8'h10);
        tick();
    endtask

    task automatic test_single();
        int de;
        run_dump(3'd3, 3'd3, -1, 0, 1'b0, de);
        n_checks++; if (de !== 2) begin n_errors++; $display("FAIL single_done_edge got %0d exp 2", de); end
        n_checks++; if (got_addr.size() !== 1 || got_addr[0] !== 3'd3 || got_data[0] !== 8'h13) begin n_errors++; $display("FAIL single_word got n=%0d %0d/%0h exp n=1 3/13", got_addr.size(), got_addr[0], got_data[0]); end
        tick();
    endtask

    task automatic test_stall();
        int de;
        run_dump(3'd0, 3'd7, 1, 3, 1'b0, de);
        n_checks++; if (de !== 19) begin n_errors++; $display("FAIL stall_done_edge got %0d exp 19", de); end
        n_checks++; if (stall_moved !== 1'b0) begin n_errors++; $display("FAIL stall_hold got moved=%b exp 0", stall_moved); end
        n_checks++; if (got_addr.size() !== 8 || got_addr[1] !== 3'd1 || got_data[1] !== 8'h11) begin n_errors++; $display("FAIL stall_word1 got n=%0d %0d/%0h exp n=8 1/11", got_addr.size(), got_addr[1], got_data[1]); end
        tick();
    endtask

    task automatic test_abort();
        int de;
        bus.first_addr = 3'd0;
        bus.last_addr  = 3'd7;
        bus.ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        n_checks++; if (bus.valid !== 1'b1 || bus.daddr !== 3'd1) begin n_errors++; $display("FAIL abort_pre got valid=%b daddr=%0d exp 1 1", bus.valid, bus.daddr); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++; if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin n_errors++; $display("FAIL abort_flags got %b exp 000", {bus.valid, bus.busy, bus.done}); end
        n_checks++; if (bus.daddr !== 3'd1 || bus.dout !== 8'h11 || bus.rdaddress !== 3'd1) begin n_errors++; $display("FAIL abort_hold got %0d/%0h/%0d exp 1/11/1", bus.daddr, bus.dout, bus.rdaddress); end
        tick();
        n_checks++; if (bus.done !== 1'b0 || dbg_state !== 2'd0) begin n_errors++; $display("FAIL abort_no_done got done=%b state=%0d exp 0 0", bus.done, dbg_state); end
        run_dump(3'd4, 3'd5, -1, 0, 1'b0, de);
        n_checks++; if (de !== 4 || got_addr.size() !== 2 || got_addr[0] !== 3'd4 || got_data[1] !== 8'h15) begin n_errors++; $display("FAIL abort_restart got done=%0d n=%0d exp 4 2", de, got_addr.size()); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.first_addr = 3'd2;
        bus.last_addr  = 3'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        n_checks++; if ({bus.rdaddress, bus.dout, bus.daddr, bus.valid, bus.busy, bus.done} !== 17'd0) begin n_errors++; $display("FAIL midreset_zero got ra=%0d dout=%0h da=%0d v=%b b=%b d=%b exp all 0", bus.rdaddress, bus.dout, bus.daddr, bus.valid, bus.busy, bus.done); end
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL midreset_start_ignored got busy=%b exp 0", bus.busy); end
        reset = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        n_checks++; if (bus.busy !== 1'b0 || dbg_state !== 2'd0) begin n_errors++; $display("FAIL start_abort_idle got busy=%b state=%0d exp 0 0", bus.busy, dbg_state); end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
    endtask

    task automatic test_start_busy();
        int de;
        run_dump(3'd2, 3'd5, -1, 0, 1'b1, de);
        n_checks++; if (de !== 8 || got_addr.size() !== 4) begin n_errors++; $display("FAIL busy_start_len got done=%0d n=%0d exp 8 4", de, got_addr.size()); end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            n_checks++; if (got_addr[i] !== 3'(i + 2)) begin n_errors++; $display("FAIL busy_start_word%0d got %0d exp %0d", i, got_addr[i], i + 2); end
        end
    endtask

    task automatic test_back_to_back();
        int de;
        run_dump(3'd0, 3'd1, -1, 0, 1'b0, de);
        n_checks++; if (de !== 4) begin n_errors++; $display("FAIL b2b_first_done got %0d exp 4", de); end
        bus.first_addr = 3'd5;
        bus.last_addr  = 3'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.rdaddress !== 3'd5 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_errors++; $display("FAIL b2b_restart got ra=%0d busy=%b done=%b exp 5 1 0", bus.rdaddress, bus.busy, bus.done); end
        tick();
        n_checks++; if (bus.valid !== 1'b1 || bus.daddr !== 3'd5 || bus.dout !== 8'h15) begin n_errors++; $display("FAIL b2b_word got v=%b %0d/%0h exp 1 5/15", bus.valid, bus.daddr, bus.dout); end
        tick();
        n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_done got done=%b busy=%b exp 1 0", bus.done, bus.busy); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ready = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        load_regs(8'h10);
        test_reset();
        test_full_dump();
        test_wrap();
        test_single();
        test_stall();
        test_abort();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
